key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 116 +++++++++++
 tb/tb_key_debounce.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronizes and debounces a 4-bit active-low keypad column bus,
//               and counts qualification windows that were aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Column_raw,
    input  logic       Clear,
    output logic [3:0] Column,
    output logic       Changed,
    output logic       Busy,
    output logic [7:0] Bounce_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    localparam logic [15:0] C_LAST_COUNT = DEBOUNCE_CYCLES - 16'd1;

    logic [3:0]  s1_q, s2_q;
    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  column_q, column_d;
    logic        changed_q, changed_d;
    logic [7:0]  bounce_q, bounce_d;
    logic        w_bounce;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        column_d  = column_q;
        changed_d = 1'b0;
        w_bounce  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s2_q != column_q) begin
                    cand_d  = s2_q;
                    cnt_d   = 16'd1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (s2_q == cand_q) begin
                    if (cnt_q == C_LAST_COUNT) begin
                        column_d  = cand_q;
                        changed_d = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (s2_q == column_q) begin
                    // Input fell back to the accepted value: abandon the window.
                    cnt_d    = 16'd0;
                    state_d  = ST_IDLE;
                    w_bounce = 1'b1;
                end else begin
                    cand_d   = s2_q;
                    cnt_d    = 16'd1;
                    w_bounce = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        bounce_d = bounce_q;
        if (Clear) begin
            bounce_d = 8'd0;
        end else if (w_bounce && (bounce_q != 8'hFF)) begin
            bounce_d = bounce_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 4'b1111;
            s2_q      <= 4'b1111;
            state_q   <= ST_IDLE;
            cand_q    <= 4'b1111;
            cnt_q     <= 16'd0;
            column_q  <= 4'b1111;
            changed_q <= 1'b0;
            bounce_q  <= 8'd0;
        end else begin
            s1_q      <= Column_raw;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            column_q  <= column_d;
            changed_q <= changed_d;
            bounce_q  <= bounce_d;
        end
    end

    assign Column       = column_q;
    assign Changed      = changed_q;
    assign Busy         = (state_q == ST_CHECK);
    assign Bounce_count = bounce_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Directed and random stimulus for key_debounce, compared against
//               a run-length reference model of the synchronized column samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam logic [15:0] C_DC = 16'd4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] Column_raw;
    logic       Clear;
    logic [3:0] Column;
    logic       Changed;
    logic       Busy;
    logic [7:0] Bounce_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two-stage sample delay, then the current run of equal
    // samples; a run of a new value reaching C_DC samples is accepted.
    logic [3:0] m_s1, m_s2, m_col, m_run;
    int         m_len;
    logic       m_chg;
    logic [7:0] m_bc;

    key_debounce #(.DEBOUNCE_CYCLES(C_DC)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .Column_raw   (Column_raw),
        .Clear        (Clear),
        .Column       (Column),
        .Changed      (Changed),
        .Busy         (Busy),
        .Bounce_count (Bounce_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic clr, input logic rst_i);
        logic [3:0] x;
        logic       bounce;
        if (rst_i) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_col = 4'hF; m_run = 4'hF;
            m_len = 0; m_chg = 1'b0; m_bc = 8'd0;
        end else begin
            x      = m_s2;
            m_s2   = m_s1;
            m_s1   = raw;
            m_chg  = 1'b0;
            bounce = 1'b0;
            if (x == m_run) begin
                if (m_len < 100000) m_len++;
            end else begin
                if (m_run != m_col) bounce = 1'b1;
                m_run = x;
                m_len = 1;
            end
            if ((m_run != m_col) && (m_len == int'(C_DC))) begin
                m_col = m_run;
                m_chg = 1'b1;
            end
            if (clr) m_bc = 8'd0;
            else if (bounce && (m_bc != 8'hFF)) m_bc = m_bc + 8'd1;
        end
    endtask

    task automatic step(input logic [3:0] raw, input logic clr, input logic rst_i);
        Column_raw = raw;
        Clear      = clr;
        reset      = rst_i;
        @(posedge clock);
        model_edge(raw, clr, rst_i);
        #1;
        check("column",  {12'd0, Column},       {12'd0, m_col});
        check("changed", {15'd0, Changed},      {15'd0, m_chg});
        check("busy",    {15'd0, Busy},         {15'd0, (m_run != m_col)});
        check("bounce",  {8'd0,  Bounce_count}, {8'd0,  m_bc});
    endtask

    initial begin
        logic [3:0] r;
        int         hold;

        Column_raw = 4'hF; Clear = 1'b0; reset = 1'b1;
        step(4'hF, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b1);
        check("rst_column", {12'd0, Column}, 16'h000F);
        for (int i = 0; i < 6; i++) step(4'hF, 1'b0, 1'b0);
        check("idle_busy", {15'd0, Busy}, 16'h0000);

        // Clean press held: busy from the third edge, commit on the sixth.
        for (int i = 1; i <= 7; i++) begin
            step(4'b1011, 1'b0, 1'b0);
            if (i == 3) check("press_busy_rise", {15'd0, Busy}, 16'h0001);
            if (i == 6) begin
                check("press_column", {12'd0, Column}, 16'h000B);
                check("press_changed", {15'd0, Changed}, 16'h0001);
            end
            if (i == 7) check("press_busy_fall", {15'd0, Busy}, 16'h0000);
        end
        for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);

        // Short glitch: rejected, counted once.
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 1'b0);
        check("glitch_column", {12'd0, Column}, 16'h000F);
        check("glitch_bounce", {8'd0, Bounce_count}, 16'h0001);
        step(4'hF, 1'b1, 1'b0);

        // Glitch followed by a different held value: restart then commit.
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b1101, 1'b0, 1'b0);
        check("restart_column", {12'd0, Column}, 16'h000D);
        check("restart_bounce", {8'd0, Bounce_count}, 16'h0001);
        for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 1'b0);

        // Saturation of the bounce counter, then Clear on an abort edge.
        for (int n = 0; n < 300; n++) begin
            step(4'b1011, 1'b0, 1'b0);
            step(4'b1011, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
        end
        check("sat_bounce", {8'd0, Bounce_count}, 16'h00FF);
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        check("clear_wins", {8'd0, Bounce_count}, 16'h0000);

        // Reset in the middle of a window, raw still pressed.
        for (int i = 0; i < 4; i++) step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b1, 1'b1);
        check("midrst_changed", {15'd0, Changed}, 16'h0000);
        check("midrst_busy", {15'd0, Busy}, 16'h0000);
        check("midrst_column", {12'd0, Column}, 16'h000F);
        for (int i = 1; i <= 7; i++) begin
            step(4'b1011, 1'b0, 1'b0);
            if (i == 6) check("requal_column", {12'd0, Column}, 16'h000B);
        end

        // Random bursts of held values, glitches, clears and resets.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       r = 4'hF;
                1:       r = 4'hF & ~(4'b0001 << $urandom_range(0, 3));
                default: r = 4'($urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                step(r, ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
